// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed 4-digit LED display bus,
// debounces each strobed digit, decodes the segment pattern to a hex nibble
// and publishes a complete 4-digit frame once every digit has been seen.
module seg7_scan_decoder #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic [15:0] value,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYC);

    logic [6:0]  segSample_q, prevSeg_q;
    logic [3:0]  selSample_q, prevSel_q;
    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  pendBlank_q, pendBlank_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  blankMask_q, blankMask_d;
    logic        frameValid_q, frameValid_d;
    logic        err_q, err_d;

    logic        selOneHot;
    logic        pairChanged;
    logic [3:0]  decNib;
    logic        decBlank;
    logic        decValid;

    // Input sample register plus a copy of the previous sample for change detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segSample_q <= '0;
            selSample_q <= '0;
            prevSeg_q   <= '0;
            prevSel_q   <= '0;
        end else begin
            segSample_q <= seg_in;
            selSample_q <= dig_sel;
            prevSeg_q   <= segSample_q;
            prevSel_q   <= selSample_q;
        end
    end

    assign selOneHot   = (selSample_q != 4'd0) && ((selSample_q & (selSample_q - 4'd1)) == 4'd0);
    assign pairChanged = (segSample_q != prevSeg_q) || (selSample_q != prevSel_q);

    // Segment pattern (g..a) to hex nibble, with blank and invalid detection
    always_comb begin
        decNib   = 4'h0;
        decBlank = 1'b0;
        decValid = 1'b1;
        case (segSample_q)
            7'b0111111: decNib = 4'h0;
            7'b0000110: decNib = 4'h1;
            7'b1011011: decNib = 4'h2;
            7'b1001111: decNib = 4'h3;
            7'b1100110: decNib = 4'h4;
            7'b1101101: decNib = 4'h5;
            7'b1111101: decNib = 4'h6;
            7'b0000111: decNib = 4'h7;
            7'b1111111: decNib = 4'h8;
            7'b1101111: decNib = 4'h9;
            7'b1110111: decNib = 4'hA;
            7'b1111100: decNib = 4'hB;
            7'b0111001: decNib = 4'hC;
            7'b1011110: decNib = 4'hD;
            7'b1111001: decNib = 4'hE;
            7'b1110001: decNib = 4'hF;
            7'b0000000: decBlank = 1'b1;
            default:    decValid = 1'b0;
        endcase
    end

    // Stability FSM, digit acceptance and frame assembly
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pending_d    = pending_q;
        pendBlank_d  = pendBlank_q;
        seen_d       = seen_q;
        value_d      = value_q;
        blankMask_d  = blankMask_q;
        frameValid_d = 1'b0;
        err_d        = 1'b0;

        if (!selOneHot) begin
            state_d = ST_WAIT;
            count_d = 4'd0;
        end else if (state_q == ST_WAIT || pairChanged) begin
            state_d = ST_COUNT;
            count_d = 4'd1;
        end else if (state_q == ST_COUNT) begin
            count_d = count_q + 4'd1;
            if (count_d == STABLE_LIM) begin
                state_d = ST_HELD;
                if (decValid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (selSample_q[i]) begin
                            pending_d[i*4 +: 4] = decNib;
                            pendBlank_d[i]      = decBlank;
                        end
                    end
                    seen_d = seen_q | selSample_q;
                    if (seen_d == 4'hF) begin
                        value_d      = pending_d;
                        blankMask_d  = pendBlank_d;
                        frameValid_d = 1'b1;
                        seen_d       = 4'd0;
                    end
                end else begin
                    err_d       = 1'b1;
                    seen_d      = 4'd0;
                    pending_d   = '0;
                    pendBlank_d = '0;
                end
            end
        end
    end

    // State, collection and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            count_q      <= '0;
            pending_q    <= '0;
            pendBlank_q  <= '0;
            seen_q       <= '0;
            value_q      <= '0;
            blankMask_q  <= '0;
            frameValid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            pendBlank_q  <= pendBlank_d;
            seen_q       <= seen_d;
            value_q      <= value_d;
            blankMask_q  <= blankMask_d;
            frameValid_q <= frameValid_d;
            err_q        <= err_d;
        end
    end

    assign value       = value_q;
    assign blank_mask  = blankMask_q;
    assign frame_valid = frameValid_q;
    assign err         = err_q;

endmodule
